// File: rtl/mkt_msg_pkg.sv
// rtl/mkt_msg_pkg.sv - shared constants, encodings and header check for the market message parser
// Contents: MSG_BYTES, field widths, action encodings, parser state encoding,
// and hdr_bad(), the b0 validity rule used at decode time.
package mkt_msg_pkg;

  localparam int MSG_BYTES  = 8;
  localparam int ORDER_ID_W = 16;
  localparam int PRICE_W    = 16;
  localparam int QTY_W      = 24;

  typedef enum logic [1:0] {
    ACT_ADD    = 2'b00,
    ACT_CANCEL = 2'b01,
    ACT_MODIFY = 2'b10,
    ACT_RSVD   = 2'b11
  } action_e;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_EMIT    = 1'b1
  } state_e;

  // b0 = {side, 5'b0, action}; a reserved action or any non-zero pad bit rejects the message
  function automatic logic hdr_bad(input logic [7:0] b0);
    return (b0[1:0] == ACT_RSVD) || (b0[6:2] != 5'd0);
  endfunction

endpackage

// File: rtl/mkt_msg_stats.sv
// rtl/mkt_msg_stats.sv - saturating accepted/rejected message counters
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_msg_inc         one-cycle strobe per accepted (handshaken) message
//   i_err_inc         one-cycle strobe per rejected message
//   o_msg_count[31:0] accepted messages, saturates at 0xFFFF_FFFF
//   o_err_count[31:0] rejected messages, saturates at 0xFFFF_FFFF
module mkt_msg_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_msg_inc,
  input  logic        i_err_inc,
  output logic [31:0] o_msg_count,
  output logic [31:0] o_err_count
);

  logic [31:0] r_msg_count;
  logic [31:0] r_err_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_msg_count <= '0;
      r_err_count <= '0;
    end else begin
      if (i_msg_inc && (r_msg_count != 32'hFFFF_FFFF)) r_msg_count <= r_msg_count + 32'd1;
      if (i_err_inc && (r_err_count != 32'hFFFF_FFFF)) r_err_count <= r_err_count + 32'd1;
    end
  end

  assign o_msg_count = r_msg_count;
  assign o_err_count = r_err_count;

endmodule

// File: rtl/mkt_msg_parser.sv
// rtl/mkt_msg_parser.sv - frames payload FIFO bytes into 8-byte order messages and emits them by valid/ready
// Optional feature macro: MKT_MSG_STATS_EN (instantiates mkt_msg_stats; otherwise counters read 0)
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   fifo_dout[7:0]        payload FIFO read data, valid one cycle after fifo_rd_en
//   fifo_empty            payload FIFO empty flag
//   fifo_rd_en            FIFO read strobe (combinational)
//   m_valid / m_ready     decoded message handshake
//   m_side, m_action      0 buy / 1 sell; 00 add, 01 cancel, 10 modify
//   m_order_id, m_price   16-bit order id, 16-bit price in ticks
//   m_qty[23:0]           quantity
//   err_pulse             one-cycle pulse per rejected message
//   msg_count, err_count  32-bit saturating statistics
module mkt_msg_parser
  import mkt_msg_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_side,
  output logic [1:0]            m_action,
  output logic [ORDER_ID_W-1:0] m_order_id,
  output logic [PRICE_W-1:0]    m_price,
  output logic [QTY_W-1:0]      m_qty,
  output logic                  err_pulse,
  output logic [31:0]           msg_count,
  output logic [31:0]           err_count
);

  localparam logic [3:0] MSG_CNT  = 4'(MSG_BYTES);
  localparam logic [3:0] LAST_IDX = 4'(MSG_BYTES - 1);

  state_e                r_state;
  logic [3:0]            r_req_cnt;
  logic [3:0]            r_cap_cnt;
  logic                  r_rd_pending;
  // b0..b6 shifted in MSB-first; b7 is taken straight from fifo_dout at decode
  logic [55:0]           r_shift;
  logic                  r_m_valid;
  logic                  r_side;
  logic [1:0]            r_action;
  logic [ORDER_ID_W-1:0] r_order_id;
  logic [PRICE_W-1:0]    r_price;
  logic [QTY_W-1:0]      r_qty;
  logic                  r_err_pulse;

  logic                  w_rd_en;
  logic [7:0]            w_b0;
  logic                  w_last_cap;
  logic                  w_reject;
  logic                  w_accept;
  logic                  w_handshake;

  // rst gate keeps the strobe low while reset is held, even if the FIFO has data
  assign w_rd_en     = !rst && (r_state == ST_COLLECT) && !fifo_empty && (r_req_cnt < MSG_CNT);
  assign w_b0        = r_shift[55:48];
  assign w_last_cap  = (r_state == ST_COLLECT) && r_rd_pending && (r_cap_cnt == LAST_IDX);
  assign w_reject    = w_last_cap && hdr_bad(w_b0);
  assign w_accept    = w_last_cap && !hdr_bad(w_b0);
  assign w_handshake = r_m_valid && m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_COLLECT;
      r_req_cnt    <= '0;
      r_cap_cnt    <= '0;
      r_rd_pending <= 1'b0;
      r_shift      <= '0;
      r_m_valid    <= 1'b0;
      r_side       <= 1'b0;
      r_action     <= 2'b00;
      r_order_id   <= '0;
      r_price      <= '0;
      r_qty        <= '0;
      r_err_pulse  <= 1'b0;
    end else begin
      r_err_pulse  <= w_reject;
      r_rd_pending <= w_rd_en;
      case (r_state)
        ST_COLLECT: begin
          if (w_rd_en) r_req_cnt <= r_req_cnt + 4'd1;
          if (w_reject) begin
            // positional framing: the very next byte read is b0 again
            r_req_cnt <= '0;
            r_cap_cnt <= '0;
          end else if (w_accept) begin
            r_side     <= w_b0[7];
            r_action   <= w_b0[1:0];
            r_order_id <= r_shift[47:32];
            r_price    <= r_shift[31:16];
            r_qty      <= {r_shift[15:0], fifo_dout};
            r_m_valid  <= 1'b1;
            r_state    <= ST_EMIT;
          end else if (r_rd_pending) begin
            r_shift   <= {r_shift[47:0], fifo_dout};
            r_cap_cnt <= r_cap_cnt + 4'd1;
          end
        end
        ST_EMIT: begin
          if (w_handshake) begin
            r_m_valid <= 1'b0;
            r_req_cnt <= '0;
            r_cap_cnt <= '0;
            r_state   <= ST_COLLECT;
          end
        end
        default: r_state <= ST_COLLECT;
      endcase
    end
  end

  assign fifo_rd_en = w_rd_en;
  assign m_valid    = r_m_valid;
  assign m_side     = r_side;
  assign m_action   = r_action;
  assign m_order_id = r_order_id;
  assign m_price    = r_price;
  assign m_qty      = r_qty;
  assign err_pulse  = r_err_pulse;

`ifdef MKT_MSG_STATS_EN
  mkt_msg_stats u_stats (
    .clk         (clk),
    .rst         (rst),
    .i_msg_inc   (w_handshake),
    .i_err_inc   (w_reject),
    .o_msg_count (msg_count),
    .o_err_count (err_count)
  );
`else
  assign msg_count = 32'd0;
  assign err_count = 32'd0;
`endif

endmodule

// File: doc/mkt_msg_parser.md
# mkt_msg_parser

Consumes the market-data payload byte FIFO (filled by the UDP payload extractor), frames the byte stream into fixed 8-byte order messages, decodes them, and presents one decoded message per valid/ready handshake to the order-book stage. It sits between the payload FIFO read port and the order book. It handles standard (non-FWFT) FIFO read latency, backpressure, and rejection of malformed messages.

## Interface
Parameters:
- MSG_BYTES, 8: bytes per message; fixed, not user-overridable.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  asynchronous, active-high reset.
- fifo_dout  in  8  payload FIFO read data; valid one cycle after fifo_rd_en.
- fifo_empty  in  1  payload FIFO empty flag.
- fifo_rd_en  out  1  FIFO read strobe; combinational from state and counters.
- m_valid  out  1  decoded message valid.
- m_ready  in  1  order book accepts the message.
- m_side  out  1  0 = buy, 1 = sell.
- m_action  out  2  00 add, 01 cancel, 10 modify.
- m_order_id  out  16  order identifier.
- m_price  out  16  price in ticks.
- m_qty  out  24  quantity.
- err_pulse  out  1  one-cycle pulse when a message is rejected.
- msg_count  out  32  accepted-message counter; present only when stats are compiled in (see Configuration).
- err_count  out  32  rejected-message counter; present only when stats are compiled in (see Configuration).

## Operation
- Wire format is big-endian, 8 bytes:
  - b0 = {side, 5'b0, action[1:0]}.
  - b1..b2 = order_id.
  - b3..b4 = price.
  - b5..b7 = qty.
- States:
  - COLLECT: reads and captures bytes.
  - EMIT: holds m_valid until handshake.
- COLLECT:
  - fifo_rd_en = !fifo_empty && req_cnt < 8.
  - req_cnt (4 bit) increments on each rd_en.
  - rd_pending is registered rd_en. When set, fifo_dout is captured into byte slot cap_cnt, and cap_cnt (4 bit) increments.
- Decode on capture of byte 7 (cap_cnt == 7 with rd_pending):
  - action == 2'b11 or b0[6:2] != 0: message rejected. err_pulse = 1 for one cycle, counters cleared, state stays COLLECT, m_valid stays 0.
  - Otherwise: fields registered onto m_* outputs, m_valid <= 1, state -> EMIT.
- EMIT:
  - fifo_rd_en = 0.
  - m_* are stable while m_valid && !m_ready.
  - On m_valid && m_ready: m_valid <= 0, req_cnt/cap_cnt <= 0, state -> COLLECT.
- FIFO empty mid-message: reads pause; partially captured bytes are held indefinitely; no timeout.
- fifo_rd_en is never asserted while fifo_empty. The block never issues more than 8 reads per message.
- Framing is positional only. After a reject, the next byte read is treated as b0; there is no resync search.
- Reset values:
  - fifo_rd_en 0, m_valid 0, all m_* fields 0, err_pulse 0, counters 0.
  - state COLLECT, req_cnt/cap_cnt 0.
- Reset mid-message discards captured bytes. Bytes already popped from the FIFO are lost.

## Timing
- FIFO read latency is 1 cycle: rd_en in cycle n, data captured at edge ending cycle n+1.
- With the FIFO continuously non-empty:
  - rd_en in cycles 0–7.
  - Captures at the ends of cycles 1–8.
  - m_valid high from cycle 9.
- Handshake in cycle k -> COLLECT in cycle k+1; first rd_en of the next message is possible in k+1.
- Peak throughput: one message per 10 cycles when m_ready is held high.
- A reject returns to COLLECT with rd_en possible in the cycle after the 8th capture; err_pulse is high in that same cycle.
- m_ready is ignored when m_valid = 0.

## Configuration
- MKT_MSG_STATS_EN defined:
  - msg_count increments on each handshake.
  - err_count increments on each reject.
  - Both are 32-bit and saturate at 0xFFFF_FFFF.
  - Both reset to 0.
- MKT_MSG_STATS_EN undefined: msg_count and err_count are driven constant 0, and no counter logic is instantiated.

## Structure
- Shared package mkt_msg_pkg:
  - MSG_BYTES.
  - Action encodings ACT_ADD/ACT_CANCEL/ACT_MODIFY/ACT_RSVD.
  - Field widths (ORDER_ID_W 16, PRICE_W 16, QTY_W 24).
  - State encoding.
- One sub-module: mkt_msg_stats, holding the two saturating counters. It is instantiated only under MKT_MSG_STATS_EN.

## Test plan
- Single add: FIFO holds 00 12 34 01 F4 00 00 64, m_ready = 1 -> one message with side 0, action 00, order_id 0x1234, price 500, qty 100. m_valid rises 9 cycles after the first rd_en.
- Backpressure: m_ready = 0 for 20 cycles, then two queued messages -> m_* stable during the stall, no rd_en while in EMIT, both messages delivered in order.
- Reject: b0 = 0x03 followed by 7 bytes, then a valid cancel with b0 = 0x81 -> err_pulse exactly once, no m_valid for the first message, cancel sell delivered; err_count = 1 with stats on.
- Starved FIFO: fifo_empty toggles every other cycle during a message -> rd_en never asserted while empty, fields correct, m_valid after the 8th capture.
- Reset mid-message: assert rst after 4 captures -> all outputs 0 immediately; the next 8 FIFO bytes form a new message.
- Stats saturation with MKT_MSG_STATS_EN: force msg_count to 0xFFFF_FFFE, deliver 3 messages -> count reads 0xFFFF_FFFF.
